// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind controller.
// Defines shape codes, controller states, pattern sizing and shape-validity checks.
package mastermind_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SHAPE_W   = 3;
    localparam int PATTERN_W = NUM_SLOTS * SHAPE_W;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_NONE = 3'b000,
        SHAPE_1    = 3'b001,
        SHAPE_2    = 3'b010,
        SHAPE_3    = 3'b011,
        SHAPE_4    = 3'b100,
        SHAPE_5    = 3'b101,
        SHAPE_6    = 3'b110,
        SHAPE_BAD  = 3'b111
    } shape_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GRADE,
        WON,
        LOST
    } ctrl_state_t;

    function automatic logic is_valid_shape(input logic [SHAPE_W-1:0] s);
        return (s != SHAPE_NONE) && (s != SHAPE_BAD);
    endfunction

    function automatic logic guess_all_valid(input logic [PATTERN_W-1:0] g);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ok = ok & is_valid_shape(g[i*SHAPE_W +: SHAPE_W]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mastermind_controller_round_counter.sv
// Saturating round counter: clear has priority, increments stop at limit.
// Ports: clock, reset, clear, incr, limit -> count, at_limit.
module round_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    assign at_limit = (count >= limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mastermind_controller.sv
// Mastermind top-level sequencer: pattern load gating, guess hand-off, win/loss.
// Ports: clock/reset; start_game; load_req/load_shape/load_loc -> loading_shape,
//   master_loaded, loaded_mask; guess_valid/guess -> grade_req, guess_q;
//   grade_valid/znarly/zood -> round_num, game_won, game_over.
// Build option MASTERMIND_GUESS_CHECK_EN: reject guesses with 000/111 slots,
//   adds guess_err output.
module mastermind_controller
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS = 8,
    parameter int ROUND_W    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_game,
    input  logic                 load_req,
    input  logic [SHAPE_W-1:0]   load_shape,
    input  logic [1:0]           load_loc,
    output logic                 loading_shape,
    output logic                 master_loaded,
    output logic [NUM_SLOTS-1:0] loaded_mask,
    input  logic                 guess_valid,
    input  logic [PATTERN_W-1:0] guess,
    output logic                 grade_req,
    output logic [PATTERN_W-1:0] guess_q,
    input  logic                 grade_valid,
    input  logic [2:0]           znarly,
    input  logic [2:0]           zood,
`ifdef MASTERMIND_GUESS_CHECK_EN
    output logic                 guess_err,
`endif
    output logic [ROUND_W-1:0]   round_num,
    output logic                 game_won,
    output logic                 game_over
);

    ctrl_state_t state, nextState;

    logic [NUM_SLOTS-1:0] maskQ;
    logic [NUM_SLOTS-1:0] maskSet;
    logic                 gradeReqQ;
    logic [PATTERN_W-1:0] guessQ;
    logic                 startNew;
    logic                 loadAccept;
    logic                 guessOk;
    logic                 guessAccept;
    logic                 gradeDone;
    logic                 isWin;
    logic                 lastRound;
    logic [ROUND_W-1:0]   roundCount;
    logic                 unusedAtLimit;
    logic                 unusedZood;

    // Zood is informational only; the controller decides on znarly alone.
    assign unusedZood = ^zood;

    // A new game may only begin from a resting state; a load in the
    // same cycle is dropped because loadAccept requires LOAD.
    assign startNew = start_game &&
        (state == IDLE || state == WON || state == LOST);

    assign loadAccept = (state == LOAD) && load_req &&
        is_valid_shape(load_shape) && !maskQ[load_loc];

    assign maskSet = loadAccept ?
        (NUM_SLOTS'(1) << load_loc) : '0;

`ifdef MASTERMIND_GUESS_CHECK_EN
    assign guessOk   = guess_all_valid(guess);
    assign guess_err = (state == PLAY) && guess_valid && !guessOk;
`else
    assign guessOk   = 1'b1;
`endif

    assign guessAccept = (state == PLAY) && guess_valid && guessOk;
    assign gradeDone   = (state == GRADE) && grade_valid;
    assign isWin       = (znarly == 3'd4);
    // The round being graded is the last one when the count is one short.
    assign lastRound   = (roundCount == ROUND_W'(MAX_ROUNDS - 1));

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE, WON, LOST: begin
                if (startNew) nextState = LOAD;
            end
            LOAD: begin
                if ((maskQ | maskSet) == '1) nextState = PLAY;
            end
            PLAY: begin
                if (guessAccept) nextState = GRADE;
            end
            GRADE: begin
                if (gradeDone) begin
                    if (isWin)          nextState = WON;
                    else if (lastRound) nextState = LOST;
                    else                nextState = PLAY;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            maskQ     <= '0;
            gradeReqQ <= 1'b0;
            guessQ    <= '0;
        end else begin
            state     <= nextState;
            gradeReqQ <= guessAccept;
            if (startNew) maskQ <= '0;
            else          maskQ <= maskQ | maskSet;
            if (guessAccept) guessQ <= guess;
        end
    end

    round_counter #(
        .WIDTH(ROUND_W)
    ) u_round (
        .clock   (clock),
        .reset   (reset),
        .clear   (startNew),
        .incr    (gradeDone),
        .limit   (ROUND_W'(MAX_ROUNDS)),
        .count   (roundCount),
        .at_limit(unusedAtLimit)
    );

    assign loading_shape = loadAccept;
    assign loaded_mask   = maskQ;
    assign master_loaded = (state == PLAY) || (state == GRADE) ||
                           (state == WON)  || (state == LOST);
    assign grade_req     = gradeReqQ;
    assign guess_q       = guessQ;
    assign round_num     = roundCount;
    assign game_won      = (state == WON);
    assign game_over     = (state == WON) || (state == LOST);

endmodule
